// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_if
// Description : Bus bundle between the writeback arbiter, the pipeline, the
//               multi-cycle unit and the register file write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic [4:0]  rsW;
    logic [31:0] dataW;
    logic        RegWEn;
    logic [31:0] pend_mask;

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
        output pipe_stall, mc_ready, rsW, dataW, RegWEn, pend_mask
    );

    modport master (
        output pipe_valid, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
        input  pipe_stall, mc_ready, rsW, dataW, RegWEn, pend_mask
    );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Register file write-port arbiter merging pipeline results with
//               FIFO-buffered multi-cycle results, with a starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_GW = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
    localparam logic [c_GW-1:0] c_AGE_MAX = c_GW'(STARVE_LIMIT);

    logic [4:0]       r_fifo_rd   [DEPTH];
    logic [31:0]      r_fifo_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [c_GW-1:0]  r_age;

    logic        w_nonempty;
    logic        w_starve;
    logic        w_pipe_wr;
    logic        w_pop;
    logic        w_push;
    logic [31:0] w_pend;

    assign w_nonempty = (r_count != '0);
    assign w_starve   = w_nonempty && (r_age >= c_AGE_MAX);
    assign w_pipe_wr  = !w_starve && bus.pipe_valid && (bus.pipe_rd != 5'd0);
    // The head drains whenever the pipeline is not claiming the port.
    assign w_pop      = w_nonempty && !w_pipe_wr && !rst;
    assign w_push     = bus.mc_valid && bus.mc_ready && (bus.mc_rd != 5'd0);

    assign bus.mc_ready   = !rst && (r_count != c_FULL);
    assign bus.pipe_stall = !rst && w_starve;
    assign bus.RegWEn     = !rst && (w_pipe_wr || w_pop);
    assign bus.rsW        = w_pipe_wr ? bus.pipe_rd   : r_fifo_rd[r_rd_ptr];
    assign bus.dataW      = w_pipe_wr ? bus.pipe_data : r_fifo_data[r_rd_ptr];
    assign bus.pend_mask  = rst ? 32'd0 : w_pend;

    always_comb begin
        w_pend = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) begin
                w_pend[r_fifo_rd[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= bus.mc_rd;
            r_fifo_data[r_wr_ptr] <= bus.mc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_age    <= '0;
            r_vld    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
                r_vld[r_wr_ptr] <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr        <= r_rd_ptr + c_AW'(1);
                r_vld[r_rd_ptr] <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            // Age tracks how long the current head has been waiting.
            if (!w_nonempty || w_pop) begin
                r_age <= '0;
            end else if (r_age < c_AGE_MAX) begin
                r_age <= r_age + c_GW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter with a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    wr_t  exp_q [$];

    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every write must be the live pipe result or the oldest accepted mc result.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.RegWEn) begin
                if (bus.pipe_valid && bus.pipe_rd != 5'd0 && !bus.pipe_stall) begin
                    checks++;
                    if (bus.rsW !== bus.pipe_rd || bus.dataW !== bus.pipe_data) begin
                        errors++;
                        $display("FAIL sb_pipe got rd=%0d data=%h exp rd=%0d data=%h",
                                 bus.rsW, bus.dataW, bus.pipe_rd, bus.pipe_data);
                    end
                end else begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected got rd=%0d data=%h exp no write",
                                 bus.rsW, bus.dataW);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        if (bus.rsW !== e.rd || bus.dataW !== e.data) begin
                            errors++;
                            $display("FAIL sb_mc got rd=%0d data=%h exp rd=%0d data=%h",
                                     bus.rsW, bus.dataW, e.rd, e.data);
                        end
                    end
                end
            end
            if (bus.mc_valid && bus.mc_ready && bus.mc_rd != 5'd0) begin
                exp_q.push_back('{rd: bus.mc_rd, data: bus.mc_data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick();
        @(negedge clk);
        checks++; if (bus.RegWEn !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", bus.RegWEn); end
        checks++; if (bus.mc_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", bus.mc_ready); end
        checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", bus.pipe_stall); end
        checks++; if (bus.pend_mask !== 32'd0) begin errors++; $display("FAIL rst_pend got=%h exp=0", bus.pend_mask); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got=%b exp=1", bus.mc_ready); end
        checks++; if (bus.RegWEn !== 1'b0) begin errors++; $display("FAIL post_rst_we got=%b exp=0", bus.RegWEn); end
    endtask

    task automatic test_single_mc;
        tick();
        bus.mc_valid = 1'b1; bus.mc_rd = 5'd5; bus.mc_data = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (bus.RegWEn !== 1'b0) begin errors++; $display("FAIL t1_no_bypass got=%b exp=0", bus.RegWEn); end
        tick();
        bus.mc_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.RegWEn !== 1'b1) begin errors++; $display("FAIL t1_we got=%b exp=1", bus.RegWEn); end
        checks++; if (bus.rsW !== 5'd5) begin errors++; $display("FAIL t1_rd got=%0d exp=5", bus.rsW); end
        checks++; if (bus.dataW !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_data got=%h exp=deadbeef", bus.dataW); end
        checks++; if (bus.pend_mask !== 32'h20) begin errors++; $display("FAIL t1_pend got=%h exp=20", bus.pend_mask); end
        tick();
        @(negedge clk);
        checks++; if (bus.pend_mask !== 32'd0) begin errors++; $display("FAIL t1_pend_clr got=%h exp=0", bus.pend_mask); end
        checks++; if (bus.RegWEn !== 1'b0) begin errors++; $display("FAIL t1_idle got=%b exp=0", bus.RegWEn); end
    endtask

    task automatic test_starvation;
        logic [31:0] d [5];
        tick();
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd7; bus.pipe_data = 32'h0000_7777;
        for (int k = 1; k <= 4; k++) begin
            d[k] = $urandom;
            bus.mc_valid = 1'b1; bus.mc_rd = 5'(k); bus.mc_data = d[k];
            @(negedge clk);
            checks++; if (bus.rsW !== 5'd7 || bus.RegWEn !== 1'b1) begin errors++; $display("FAIL t2_pipe_prio got rd=%0d we=%b exp rd=7 we=1", bus.rsW, bus.RegWEn); end
            checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL t2_ready got=%b exp=1", bus.mc_ready); end
            tick();
        end
        bus.mc_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.mc_ready !== 1'b0) begin errors++; $display("FAIL t2_full got=%b exp=0", bus.mc_ready); end
        checks++; if (bus.pend_mask !== 32'h1E) begin errors++; $display("FAIL t2_pend got=%h exp=1e", bus.pend_mask); end
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            if (c < 4) begin
                checks++; if (bus.pipe_stall !== 1'b0 || bus.rsW !== 5'd7) begin errors++; $display("FAIL t3_wait got stall=%b rd=%0d exp stall=0 rd=7", bus.pipe_stall, bus.rsW); end
            end else begin
                checks++; if (bus.pipe_stall !== 1'b1 || bus.rsW !== 5'd1 || bus.dataW !== d[1]) begin
                    errors++; $display("FAIL t3_starve got stall=%b rd=%0d data=%h exp stall=1 rd=1 data=%h", bus.pipe_stall, bus.rsW, bus.dataW, d[1]);
                end
            end
        end
        tick();
        @(negedge clk);
        checks++; if (bus.pipe_stall !== 1'b0 || bus.rsW !== 5'd7) begin errors++; $display("FAIL t3_resume got stall=%b rd=%0d exp stall=0 rd=7", bus.pipe_stall, bus.rsW); end
        tick();
        bus.pipe_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            checks++; if (bus.RegWEn !== 1'b1 || bus.rsW !== 5'(k) || bus.dataW !== d[k]) begin
                errors++; $display("FAIL t3_drain got we=%b rd=%0d data=%h exp we=1 rd=%0d data=%h", bus.RegWEn, bus.rsW, bus.dataW, k, d[k]);
            end
            tick();
        end
        @(negedge clk);
        checks++; if (bus.RegWEn !== 1'b0 || bus.pend_mask !== 32'd0) begin errors++; $display("FAIL t3_empty got we=%b pend=%h exp we=0 pend=0", bus.RegWEn, bus.pend_mask); end
    endtask

    task automatic test_rd_zero;
        tick();
        bus.mc_valid = 1'b1; bus.mc_rd = 5'd0; bus.mc_data = 32'h1234_5678;
        @(negedge clk);
        checks++; if (bus.RegWEn !== 1'b0) begin errors++; $display("FAIL t4_x0_we got=%b exp=0", bus.RegWEn); end
        tick();
        bus.mc_rd = 5'd9; bus.mc_data = 32'h0900_0009;
        @(negedge clk);
        checks++; if (bus.RegWEn !== 1'b0 || bus.pend_mask !== 32'd0) begin errors++; $display("FAIL t4_x0_dropped got we=%b pend=%h exp we=0 pend=0", bus.RegWEn, bus.pend_mask); end
        tick();
        bus.mc_valid = 1'b0;
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd0; bus.pipe_data = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (bus.RegWEn !== 1'b1 || bus.rsW !== 5'd9 || bus.dataW !== 32'h0900_0009) begin
            errors++; $display("FAIL t4_pipe_x0 got we=%b rd=%0d data=%h exp we=1 rd=9 data=09000009", bus.RegWEn, bus.rsW, bus.dataW);
        end
        checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL t4_stall got=%b exp=0", bus.pipe_stall); end
        tick();
        bus.pipe_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.RegWEn !== 1'b0 || bus.pend_mask !== 32'd0) begin errors++; $display("FAIL t4_empty got we=%b pend=%h exp we=0 pend=0", bus.RegWEn, bus.pend_mask); end
    endtask

    task automatic test_mid_reset;
        tick();
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd7; bus.pipe_data = 32'h0000_0707;
        for (int k = 0; k < 3; k++) begin
            bus.mc_valid = 1'b1; bus.mc_rd = 5'(20 + k); bus.mc_data = $urandom;
            tick();
        end
        bus.mc_valid = 1'b0; bus.pipe_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.RegWEn !== 1'b0 || bus.pend_mask !== 32'd0 || bus.mc_ready !== 1'b0) begin
            errors++; $display("FAIL t5_in_rst got we=%b pend=%h ready=%b exp we=0 pend=0 ready=0", bus.RegWEn, bus.pend_mask, bus.mc_ready);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (bus.RegWEn !== 1'b0 || bus.pend_mask !== 32'd0) begin
                errors++; $display("FAIL t5_discard got we=%b rd=%0d pend=%h exp we=0 pend=0", bus.RegWEn, bus.rsW, bus.pend_mask);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d [6];
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd7; bus.pipe_data = 32'h0000_0077;
        for (int k = 0; k < 3; k++) begin
            d[k] = $urandom;
            bus.mc_valid = 1'b1; bus.mc_rd = 5'(10 + k); bus.mc_data = d[k];
            @(negedge clk);
            checks++; if (bus.rsW !== 5'd7) begin errors++; $display("FAIL t6_fill got rd=%0d exp=7", bus.rsW); end
            tick();
        end
        bus.pipe_valid = 1'b0;
        for (int k = 3; k < 6; k++) begin
            d[k] = $urandom;
            bus.mc_valid = 1'b1; bus.mc_rd = 5'(10 + k); bus.mc_data = d[k];
            @(negedge clk);
            checks++; if (bus.RegWEn !== 1'b1 || bus.rsW !== 5'(7 + k) || bus.dataW !== d[k-3]) begin
                errors++; $display("FAIL t6_pushpop got we=%b rd=%0d data=%h exp we=1 rd=%0d data=%h", bus.RegWEn, bus.rsW, bus.dataW, 7 + k, d[k-3]);
            end
            checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL t6_ready got=%b exp=1", bus.mc_ready); end
            if (k == 4) begin
                checks++; if (bus.pend_mask !== 32'h3800) begin errors++; $display("FAIL t6_pend got=%h exp=3800", bus.pend_mask); end
            end
            tick();
        end
        bus.mc_valid = 1'b0;
        for (int k = 3; k < 6; k++) begin
            @(negedge clk);
            checks++; if (bus.RegWEn !== 1'b1 || bus.rsW !== 5'(10 + k) || bus.dataW !== d[k]) begin
                errors++; $display("FAIL t6_order got we=%b rd=%0d data=%h exp we=1 rd=%0d data=%h", bus.RegWEn, bus.rsW, bus.dataW, 10 + k, d[k]);
            end
            tick();
        end
        @(negedge clk);
        checks++; if (bus.RegWEn !== 1'b0 || bus.pend_mask !== 32'd0) begin errors++; $display("FAIL t6_empty got we=%b pend=%h exp we=0 pend=0", bus.RegWEn, bus.pend_mask); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.pipe_valid = 1'b0; bus.pipe_rd = 5'd0; bus.pipe_data = 32'd0;
        bus.mc_valid = 1'b0; bus.mc_rd = 5'd0; bus.mc_data = 32'd0;
        test_reset();
        test_single_mc();
        test_starvation();
        test_rd_zero();
        test_mid_reset();
        test_back_to_back();
        @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
